// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between two single-byte requesters.
// Holds enable only until the controller leaves idle, then waits for ready, with timeout and gap.
module i2c_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [13:0] addr,
  input  logic [15:0] wdata,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        i2c_enable,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_data_in,
  input  logic        i2c_ready,
  input  logic [7:0]  i2c_data_out
);

  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        grant_r, grant_s;
  logic [1:0]        done_r, done_s;
  logic [7:0]        rdata_r, rdata_s;
  logic              err_r, err_s;
  logic              en_r, en_s;
  logic [6:0]        addr_r, addr_s;
  logic              rw_r, rw_s;
  logic [7:0]        data_r, data_s;
  logic              last_r, last_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
  logic              win_s;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    done_s    = 2'b00;
    rdata_s   = rdata_r;
    err_s     = 1'b0;
    en_s      = en_r;
    addr_s    = addr_r;
    rw_s      = rw_r;
    data_s    = data_r;
    last_s    = last_r;
    to_cnt_s  = to_cnt_r;
    gap_cnt_s = gap_cnt_r;
    // On a tie the port that did not win last time goes next.
    win_s     = (req == 2'b11) ? ~last_r : req[1];

    case (state_r)
      ST_IDLE: begin
        if ((req != 2'b00) && i2c_ready) begin
          grant_s  = win_s ? 2'b10 : 2'b01;
          last_s   = win_s;
          addr_s   = win_s ? addr[13:7] : addr[6:0];
          rw_s     = win_s ? rw[1] : rw[0];
          data_s   = win_s ? wdata[15:8] : wdata[7:0];
          en_s     = 1'b1;
          to_cnt_s = '0;
          state_s  = ST_LAUNCH;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (to_cnt_r == TO_LAST) begin
          en_s      = 1'b0;
          done_s    = grant_r;
          err_s     = 1'b1;
          grant_s   = 2'b00;
          gap_cnt_s = '0;
          state_s   = ST_GAP;
        end else if (!i2c_ready) begin
          // Dropping enable here makes the controller stop after this byte.
          en_s      = 1'b0;
          to_cnt_s  = to_cnt_r + TO_ONE;
          state_s   = ST_BUSY;
        end else begin
          to_cnt_s  = to_cnt_r + TO_ONE;
        end
      end
      ST_BUSY: begin
        if (i2c_ready) begin
          done_s    = grant_r;
          rdata_s   = rw_r ? i2c_data_out : rdata_r;
          grant_s   = 2'b00;
          gap_cnt_s = '0;
          state_s   = ST_GAP;
        end else if (to_cnt_r == TO_LAST) begin
          en_s      = 1'b0;
          done_s    = grant_r;
          err_s     = 1'b1;
          grant_s   = 2'b00;
          gap_cnt_s = '0;
          state_s   = ST_GAP;
        end else begin
          to_cnt_s  = to_cnt_r + TO_ONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
        en_s    = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 2'b00;
      done_r    <= 2'b00;
      rdata_r   <= 8'h00;
      err_r     <= 1'b0;
      en_r      <= 1'b0;
      addr_r    <= 7'h00;
      rw_r      <= 1'b0;
      data_r    <= 8'h00;
      last_r    <= 1'b1;
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      en_r      <= en_s;
      addr_r    <= addr_s;
      rw_r      <= rw_s;
      data_r    <= data_s;
      last_r    <= last_s;
      to_cnt_r  <= to_cnt_s;
      gap_cnt_r <= gap_cnt_s;
    end
  end

  assign grant       = grant_r;
  assign done        = done_r;
  assign rdata       = rdata_r;
  assign err         = err_r;
  assign i2c_enable  = en_r;
  assign i2c_addr    = addr_r;
  assign i2c_rw      = rw_r;
  assign i2c_data_in = data_r;

endmodule
